obstacle_spawn_scheduler: RTL and testbench
===========================================

Name: obstacle_spawn_scheduler

Overview:
- Decides when the next obstacle appears and which obstacle slot (small cactus, big cactus or bird sprite module) launches it.
- Replaces ad-hoc random selection on a slow divided clock with a single-clock FSM: randomised inter-spawn gap, free-slot scan, and start/finish handshake with each slot.
- Sits between the clock divider (tick strobe), the game-state logic (enable) and the obstacle sprite modules (start out, finish/idle in).

Parameters:
- N_OBS, 6, number of obstacle slots. Range 2..16. IDX_W = $clog2(N_OBS), derived.
- GAP_MIN, 2, minimum ticks between spawns. Must be >= 1.
- GAP_RAND_W, 3, width of the random extra gap. Extra gap is 0..2^GAP_RAND_W-1 ticks.
- ACK_TO, 64, clock cycles to wait for a slot to acknowledge start.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle spawn-timebase strobe, synchronous to clk.
- enable  in  1  game running. 0 = pause and abort.
- idle  in  N_OBS  per-slot finish flag. 1 = slot off-screen and free.
- start  out  N_OBS  per-slot launch request. At most one bit high.
- last_sel  out  IDX_W  index of the most recently launched slot.
- spawn_count  out  16  count of successful launches. Wraps at 16'hFFFF to 0.
- ack_err  out  1  sticky flag: a slot failed to acknowledge within ACK_TO.

Behaviour:
- Reset values: start=0, last_sel=0, spawn_count=0, ack_err=0, state OFF, lfsr=LFSR_SEED, gap_cnt=0, ptr=0.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Steps every clk cycle regardless of state. Never reaches 0.
- States: OFF, GAP, PICK, SCAN, ACK.
- OFF: start=0. When enable=1, go to GAP and load gap_cnt = GAP_MIN + lfsr[GAP_RAND_W-1:0].
- GAP: on tick, gap_cnt decrements. On a tick with gap_cnt==1, go to PICK. Ticks outside GAP are ignored.
- PICK (1 cycle): ptr = lfsr[7:0] mod N_OBS, scanned = 0, then go to SCAN.
- SCAN: tests one slot per cycle.
  - If idle[ptr]=1: next cycle start[ptr]=1, last_sel=ptr, to_cnt=0, go to ACK.
  - Otherwise ptr advances by 1, wrapping N_OBS-1 to 0, and scanned increments.
  - If scanned==N_OBS-1 and there is still no hit, go to GAP with gap_cnt=1 (retry on the next tick).
  - Worst case from PICK to start assertion is N_OBS+1 cycles.
- ACK: start[last_sel] is held high. to_cnt increments each cycle.
  - If idle[last_sel]=0 (slot acknowledged): start=0 next cycle, spawn_count+1, go to GAP with a fresh random gap.
  - Else if to_cnt==ACK_TO-1: start=0, ack_err=1, no count, go to GAP with a fresh gap.
  - If ack and timeout occur in the same cycle, ack wins.
- enable=0 in any state: next cycle go to OFF, start=0. A pending ack is abandoned and not counted. spawn_count, ack_err and last_sel hold. enable overrides every other same-cycle event.
- tick coinciding with a state transition is consumed only in GAP.
- ack_err clears only on rst.
- Asynchronous rst mid-operation forces all reset values immediately. start drops with no clock edge required.
- Slot modules are expected to drop idle within ACK_TO cycles of start and may sample start on any clk edge while it is held.

Test Plan:
- Assert rst at t0 with a random prior state -> start=0, spawn_count=0, ack_err=0, last_sel=0 immediately. The FSM stays in OFF while enable=0 despite 10 ticks.
- Set GAP_MIN=2, GAP_RAND_W=0, all idle=1, enable=1, tick every 4 cycles. The slot model drops idle 3 cycles after start -> exactly one start bit rises within 8 cycles after the 2nd tick. It falls the cycle after idle drops; spawn_count=1, last_sel equals the high bit.
- Hold idle=6'b010000 -> every launch selects slot 4 (start=6'b010000), for any LFSR pick. Start assertion occurs at most 7 cycles after PICK.
- Hold idle=0 for 20 ticks -> start never asserts, spawn_count unchanged, one PICK/SCAN sweep per tick. Setting idle[1]=1 -> start[1] on the following sweep.
- Set ACK_TO=8 with a slot model that never drops idle -> start high for exactly 8 cycles, then 0. ack_err=1, spawn_count unchanged, the next spawn still proceeds.
- Deassert enable while in ACK -> start=0 next cycle, spawn_count unchanged. Re-enable -> a fresh gap is loaded. Assert rst mid-SCAN -> all outputs reset asynchronously.

Source files
------------

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler: picks when the next obstacle spawns and which free slot launches it
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   i_tick        one-cycle spawn-timebase strobe
//   i_enable      game running; 0 pauses and aborts any launch in progress
//   i_idle        per-slot free flag (1 = slot off-screen and available)
//   o_start       per-slot launch request, at most one bit high
//   o_last_sel    index of the most recently launched slot
//   o_spawn_count number of acknowledged launches (wraps)
//   o_ack_err     sticky: a slot failed to acknowledge in time
module obstacle_spawn_scheduler #(
    parameter int          N_OBS      = 6,
    parameter int          GAP_MIN    = 2,
    parameter int          GAP_RAND_W = 3,
    parameter int          ACK_TO     = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         IDX_W      = $clog2(N_OBS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic [N_OBS-1:0] i_idle,
    output logic [N_OBS-1:0] o_start,
    output logic [IDX_W-1:0] o_last_sel,
    output logic [15:0]      o_spawn_count,
    output logic             o_ack_err
);
    typedef enum logic [2:0] {S_OFF, S_GAP, S_PICK, S_SCAN, S_ACK} state_t;

    // an all-zero seed would lock the LFSR
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam int          TO_W  = $clog2(ACK_TO + 1);
    localparam int          GAP_W = 16;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_scanned;
    logic [TO_W-1:0]    r_to_cnt;
    logic [N_OBS-1:0]   r_start;
    logic [IDX_W-1:0]   r_last_sel;
    logic [15:0]        r_spawn_count;
    logic               r_ack_err;

    logic               w_lfsr_fb;
    logic [GAP_W-1:0]   w_fresh_gap;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_ptr_next;

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_pick     = IDX_W'(r_lfsr[7:0] % 8'(N_OBS));
    assign w_ptr_next = (r_ptr == IDX_W'(N_OBS - 1)) ? '0 : r_ptr + 1'b1;

    // a zero-width random field means a fixed gap of GAP_MIN ticks
    if (GAP_RAND_W == 0) begin : g_fixed_gap
        assign w_fresh_gap = GAP_W'(GAP_MIN);
    end else begin : g_rand_gap
        assign w_fresh_gap = GAP_W'(GAP_MIN) + GAP_W'(r_lfsr[GAP_RAND_W-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_OFF;
            r_lfsr        <= SEED;
            r_gap_cnt     <= '0;
            r_ptr         <= '0;
            r_scanned     <= '0;
            r_to_cnt      <= '0;
            r_start       <= '0;
            r_last_sel    <= '0;
            r_spawn_count <= '0;
            r_ack_err     <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (!i_enable) begin
                r_state <= S_OFF;
                r_start <= '0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= w_fresh_gap;
                    end
                    S_GAP: begin
                        if (i_tick) begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                            if (r_gap_cnt == GAP_W'(1)) r_state <= S_PICK;
                        end
                    end
                    S_PICK: begin
                        r_ptr     <= w_pick;
                        r_scanned <= '0;
                        r_state   <= S_SCAN;
                    end
                    S_SCAN: begin
                        if (i_idle[r_ptr]) begin
                            r_start    <= N_OBS'(1) << r_ptr;
                            r_last_sel <= r_ptr;
                            r_to_cnt   <= '0;
                            r_state    <= S_ACK;
                        end else if (r_scanned == IDX_W'(N_OBS - 1)) begin
                            // full sweep missed: retry on the very next tick
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_W'(1);
                        end else begin
                            r_ptr     <= w_ptr_next;
                            r_scanned <= r_scanned + 1'b1;
                        end
                    end
                    S_ACK: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        // acknowledge checked first so it wins over a coincident timeout
                        if (!i_idle[r_last_sel]) begin
                            r_start       <= '0;
                            r_spawn_count <= r_spawn_count + 16'd1;
                            r_state       <= S_GAP;
                            r_gap_cnt     <= w_fresh_gap;
                        end else if (r_to_cnt == TO_W'(ACK_TO - 1)) begin
                            r_start   <= '0;
                            r_ack_err <= 1'b1;
                            r_state   <= S_GAP;
                            r_gap_cnt <= w_fresh_gap;
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign o_start       = r_start;
    assign o_last_sel    = r_last_sel;
    assign o_spawn_count = r_spawn_count;
    assign o_ack_err     = r_ack_err;
endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb_obstacle_spawn_scheduler: directed self-checking bench for obstacle_spawn_scheduler
module tb_obstacle_spawn_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        enable;
    logic [5:0]  idle;
    logic [5:0]  start;
    logic [2:0]  last_sel;
    logic [15:0] spawn_count;
    logic        ack_err;

    int checks = 0;
    int errors = 0;

    obstacle_spawn_scheduler #(
        .N_OBS(6), .GAP_MIN(2), .GAP_RAND_W(0), .ACK_TO(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_enable(enable), .i_idle(idle),
        .o_start(start), .o_last_sel(last_sel), .o_spawn_count(spawn_count), .o_ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (start == 6'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic two_ticks();
        do_tick();
        cyc(3);
        do_tick();
    endtask

    initial begin
        int n;
        int hi;
        bit quiet;
        rst = 1'b1; tick = 1'b0; enable = 1'b0; idle = 6'b111111;
        #1;
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_count", 32'(spawn_count), 32'h0);
        chk("rst_err", 32'(ack_err), 32'h0);
        chk("rst_sel", 32'(last_sel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            for (int j = 0; j < 3; j++) begin
                if (start != 6'b0) quiet = 1'b0;
                @(negedge clk);
            end
        end
        chk("off_no_start", 32'(quiet), 32'h1);
        chk("off_count", 32'(spawn_count), 32'h0);

        // fixed gap of 2 ticks, every slot free: start 2 cycles after the 2nd tick
        enable = 1'b1;
        cyc(1);
        two_ticks();
        wait_start(8, n);
        chk("first_latency", 32'(n), 32'd2);
        chk("first_onehot", 32'($onehot(start)), 32'h1);
        chk("first_sel_match", 32'(start), 32'(6'b1 << last_sel));
        cyc(3);
        chk("first_held", 32'($onehot(start)), 32'h1);
        idle[last_sel] = 1'b0;
        @(negedge clk);
        chk("first_drop", 32'(start), 32'h0);
        chk("first_count", 32'(spawn_count), 32'd1);
        idle = 6'b111111;

        // only slot 4 free: always picked regardless of LFSR start point
        for (int k = 0; k < 2; k++) begin
            idle = 6'b010000;
            two_ticks();
            wait_start(8, n);
            chk("s4_latency", 32'(n >= 2 && n <= 7), 32'h1);
            chk("s4_start", 32'(start), 32'(6'b010000));
            chk("s4_sel", 32'(last_sel), 32'd4);
            idle = 6'b000000;
            @(negedge clk);
            chk("s4_drop", 32'(start), 32'h0);
            chk("s4_count", 32'(spawn_count), 32'(k + 2));
        end

        // no free slot: one fruitless sweep per tick, no launch
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            for (int j = 0; j < 7; j++) begin
                if (start != 6'b0) quiet = 1'b0;
                @(negedge clk);
            end
        end
        chk("busy_no_start", 32'(quiet), 32'h1);
        chk("busy_count", 32'(spawn_count), 32'd3);
        idle = 6'b000010;
        do_tick();
        wait_start(8, n);
        chk("s1_latency", 32'(n >= 2 && n <= 7), 32'h1);
        chk("s1_start", 32'(start), 32'(6'b000010));
        chk("s1_sel", 32'(last_sel), 32'd1);
        chk("pre_to_err", 32'(ack_err), 32'h0);

        // slot never acknowledges: start held exactly ACK_TO cycles
        hi = 0;
        while (start != 6'b0 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk("to_width", 32'(hi), 32'd8);
        chk("to_err", 32'(ack_err), 32'h1);
        chk("to_count", 32'(spawn_count), 32'd3);
        idle = 6'b111111;
        two_ticks();
        wait_start(8, n);
        chk("post_to_latency", 32'(n), 32'd2);
        chk("post_to_onehot", 32'($onehot(start)), 32'h1);

        // drop enable while waiting for ack: launch abandoned, nothing counted
        enable = 1'b0;
        @(negedge clk);
        chk("abort_start", 32'(start), 32'h0);
        chk("abort_count", 32'(spawn_count), 32'd3);
        chk("abort_err_sticky", 32'(ack_err), 32'h1);
        enable = 1'b1;
        cyc(1);
        do_tick();
        quiet = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (start != 6'b0) quiet = 1'b0;
            @(negedge clk);
        end
        chk("reen_one_tick_quiet", 32'(quiet), 32'h1);
        do_tick();
        wait_start(8, n);
        chk("reen_latency", 32'(n), 32'd2);
        idle = 6'b000000;
        @(negedge clk);
        chk("reen_drop", 32'(start), 32'h0);
        chk("reen_count", 32'(spawn_count), 32'd4);

        // asynchronous reset in the middle of a sweep
        two_ticks();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_start", 32'(start), 32'h0);
        chk("arst_count", 32'(spawn_count), 32'h0);
        chk("arst_err", 32'(ack_err), 32'h0);
        chk("arst_sel", 32'(last_sel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
